bcd_seg_scanner: RTL and testbench

Downstream consumer of the 8-digit packed-BCD decimal counter value. Snapshots the BCD word once per display frame and time-multiplexes it onto a shared 8-bit segment bus with one-hot digit enables. Each digit slot starts with a blanking gap to suppress ghosting, and the block emits a per-frame strobe. Sits between the decimal counter and the board seven-segment pins.

---
 rtl/bcd_seg_scanner.sv | 159 +++++++++++++++
 tb/tb_bcd_seg_scanner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bcd_seg_scanner.sv
// Snapshots a packed-BCD word once per frame and multiplexes it onto a seven-segment bus.
// Optional LEADING_ZERO_BLANK_EN turns off leading zero digits (digit 0 always shown).
module bcd_seg_scanner #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W:0]   BLANK_LIM = (CNT_W + 1)'(BLANK_CYCLES);
    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{SEG_ACTIVE_LOW}};

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic                load_pending_q, load_pending_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    phase_e              phase_s;
    logic                slot_end_s;
    logic                frame_end_s;
    logic                show_s;
    logic [3:0]          nib_s;
    logic [7:0]          seg_ah_s;
    logic [DIGITS-1:0]   an_ah_s;

    // Active-high segment pattern {dp,g..a}; non-decimal nibbles show a dash
    function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = 8'h3F;
            4'd1:    pat = 8'h06;
            4'd2:    pat = 8'h5B;
            4'd3:    pat = 8'h4F;
            4'd4:    pat = 8'h66;
            4'd5:    pat = 8'h6D;
            4'd6:    pat = 8'h7D;
            4'd7:    pat = 8'h07;
            4'd8:    pat = 8'h7F;
            4'd9:    pat = 8'h6F;
            default: pat = 8'h40;
        endcase
        return pat;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz_s;
    logic              zero_above_s;

    // Mark digits that are zero along with every more-significant digit
    always_comb begin
        lz_s         = '0;
        zero_above_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above_s = zero_above_s & (snap_q[4*i +: 4] == 4'd0);
            lz_s[i]      = zero_above_s;
        end
    end
`endif

    // Slot phase, frame timing and next-state/pin values
    always_comb begin
        slot_end_s  = (cnt_q == CNT_LAST);
        frame_end_s = slot_end_s && (idx_q == IDX_LAST);
        nib_s       = snap_q[{idx_q, 2'b00} +: 4];
        seg_ah_s    = seg7_decode(nib_s);
        an_ah_s     = DIGITS'(1'b1) << idx_q;

        if ({1'b0, cnt_q} < BLANK_LIM) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_SHOW;
        end

`ifdef LEADING_ZERO_BLANK_EN
        show_s = ~lz_s[idx_q];
`else
        show_s = 1'b1;
`endif

        if (slot_end_s) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        // The frame-end load coincides with the idx wrap, so digit 0 always sees fresh data
        if (load_pending_q || frame_end_s) begin
            snap_d = bcd_in;
        end else begin
            snap_d = snap_q;
        end
        load_pending_d = 1'b0;
        frame_done_d   = frame_end_s;

        case (phase_s)
            PH_SHOW: begin
                if (show_s) begin
                    seg_d = SEG_ACTIVE_LOW ? ~seg_ah_s : seg_ah_s;
                    an_d  = SEG_ACTIVE_LOW ? ~an_ah_s  : an_ah_s;
                end else begin
                    seg_d = SEG_OFF;
                    an_d  = AN_OFF;
                end
            end
            default: begin
                seg_d = SEG_OFF;
                an_d  = AN_OFF;
            end
        endcase
    end

    // State and registered pin drivers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            snap_q         <= '0;
            load_pending_q <= 1'b1;
            frame_done_q   <= 1'b0;
            seg_q          <= SEG_OFF;
            an_q           <= AN_OFF;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            load_pending_q <= load_pending_d;
            frame_done_q   <= frame_done_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with DIGITS=8, SCAN_DIV=4, BLANK_CYCLES=1, active-low pins.
// Define LEADING_ZERO_BLANK_EN for both files to exercise leading-zero blanking.
module tb_bcd_seg_scanner;

    logic        clk;
    logic        reset_n;
    logic [31:0] bcd_in;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    int total_cnt;
    int bad_cnt;
    int k;

    // Expected active-low segment pattern and enable for each digit of the current snapshot
    logic [7:0] exp_seg [8];
    logic       exp_on  [8];

    bcd_seg_scanner #(
        .DIGITS        (8),
        .SCAN_DIV      (4),
        .BLANK_CYCLES  (1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bcd_in    (bcd_in),
        .seg       (seg),
        .an        (an),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        if (obs !== exp_v) begin
            bad_cnt++;
            $display("FAIL %s at k=%0d: got %0h want %0h", tag, k, obs, exp_v);
        end
    endtask

    task automatic set_tbl(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                           input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] s5,
                           input logic [7:0] s6, input logic [7:0] s7, input logic [7:0] on_mask);
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        exp_seg[4] = s4; exp_seg[5] = s5; exp_seg[6] = s6; exp_seg[7] = s7;
        for (int i = 0; i < 8; i++) exp_on[i] = on_mask[i];
    endtask

    // One clock edge, then compare pins against the slot the scanner was in before that edge
    task automatic step();
        int         c;
        int         d;
        logic [7:0] want_an;
        logic [7:0] want_seg;
        @(posedge clk);
        #1;
        k++;
        c = (k - 1) % 4;
        d = ((k - 1) / 4) % 8;
        if (c == 0 || !exp_on[d]) begin
            want_an  = 8'hFF;
            want_seg = 8'hFF;
        end else begin
            want_an  = ~(8'h01 << d);
            want_seg = exp_seg[d];
        end
        chk("an", {24'h0, an}, {24'h0, want_an});
        chk("seg", {24'h0, seg}, {24'h0, want_seg});
        chk("frame_done", {31'h0, frame_done}, {31'h0, (k % 32) == 0});
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        k         = 0;
        reset_n   = 1'b0;
        bcd_in    = 32'h1234_5678;
        set_tbl(8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hFF);
        #23;
        chk("rst_seg", {24'h0, seg}, 32'h0000_00FF);
        chk("rst_an", {24'h0, an}, 32'h0000_00FF);
        chk("rst_fd", {31'h0, frame_done}, 32'h0);
        reset_n = 1'b1;

        // Two frames of 0x12345678; new input arrives while digit 3 is on and must not tear
        for (int n = 0; n < 64; n++) begin
            step();
            if (k == 45) bcd_in = 32'h8765_4321;
        end
        set_tbl(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'hFF);
        for (int n = 0; n < 32; n++) begin
            step();
            if (k == 70) bcd_in = 32'h0000_000A;
        end
`ifdef LEADING_ZERO_BLANK_EN
        set_tbl(8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h01);
`else
        set_tbl(8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF);
`endif
        for (int n = 0; n < 32; n++) begin
            step();
`ifdef LEADING_ZERO_BLANK_EN
            if (k == 110) bcd_in = 32'h0000_0042;
`endif
        end
`ifdef LEADING_ZERO_BLANK_EN
        set_tbl(8'hA4, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03);
        for (int n = 0; n < 32; n++) begin
            step();
            if (k == 140) bcd_in = 32'h0000_0000;
        end
        set_tbl(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01);
        for (int n = 0; n < 32; n++) step();
`endif

        // Reset asserted while digit 0 is lit must blank the pins at once
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_seg", {24'h0, seg}, 32'h0000_00FF);
        chk("midrst_an", {24'h0, an}, 32'h0000_00FF);
        chk("midrst_fd", {31'h0, frame_done}, 32'h0);
        @(posedge clk);
        #1;
        chk("hold_an", {24'h0, an}, 32'h0000_00FF);
        reset_n = 1'b1;
        k = 0;
        for (int n = 0; n < 8; n++) step();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
